// File: rtl/btb_pkg.sv
// Shared definitions for the fully-associative branch target buffer.
//
// Contents:
//   CTR_W_DEFAULT   default width of the per-entry confidence counter
//   TAG_W           tag width (PC[31:2], instructions are word aligned)
//   btb_entry_t     per-entry valid / tag / target record
//   ctr_init_val    counter value written on allocation (weakly taken)
//   ctr_thresh_val  smallest counter value that predicts taken
//   ctr_max_val     saturation ceiling of the counter

package btb_pkg;

    localparam int CTR_W_DEFAULT = 2;
    localparam int TAG_W         = 30;

    // The counter is kept outside the struct because its width is a
    // module parameter and package typedefs cannot be parameterised.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
    } btb_entry_t;

    function automatic int ctr_init_val(input int ctr_w);
        return 1 << (ctr_w - 1);
    endfunction

    function automatic int ctr_thresh_val(input int ctr_w);
        return 1 << (ctr_w - 1);
    endfunction

    function automatic int ctr_max_val(input int ctr_w);
        return (1 << ctr_w) - 1;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU replacement state for a fully-associative structure.
//
// Nodes are numbered heap style: node 1 is the root, the children of node n
// are 2n (lower-index half) and 2n+1 (upper-index half). A node bit of 0
// means the victim lies in the lower-index subtree.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears all bits)
//   flush           synchronous clear of all bits, beats both touches
//   touch_a_valid   first touch request (applied first)
//   touch_a_idx     entry index of the first touch
//   touch_b_valid   second touch request (applied last, wins shared nodes)
//   touch_b_idx     entry index of the second touch
//   victim          entry currently selected for replacement

module plru_tree #(
    parameter int  ENTRIES = 8,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             touch_a_valid,
    input  logic [IDX_W-1:0] touch_a_idx,
    input  logic             touch_b_valid,
    input  logic [IDX_W-1:0] touch_b_idx,
    output logic [IDX_W-1:0] victim
);

    logic [ENTRIES-1:1] bits;
    logic [ENTRIES-1:1] bits_next;

    // Walk root to leaf along the path of idx; every node on the way is
    // set to point at the sibling subtree, away from the touched entry.
    function automatic logic [ENTRIES-1:1] apply_touch(
        input logic [ENTRIES-1:1] cur,
        input logic [IDX_W-1:0]   idx
    );
        logic [ENTRIES-1:1] res;
        logic [IDX_W-1:0]   node;
        logic               dir;
        res  = cur;
        node = IDX_W'(1);
        for (int l = 0; l < IDX_W; l++) begin
            dir       = idx[IDX_W-1-l];
            res[node] = ~dir;
            node      = (node << 1) | IDX_W'(dir);
        end
        return res;
    endfunction

    always_comb begin
        bits_next = bits;
        if (touch_a_valid) begin
            bits_next = apply_touch(bits_next, touch_a_idx);
        end
        if (touch_b_valid) begin
            bits_next = apply_touch(bits_next, touch_b_idx);
        end
    end

    // Follow the node bits from the root; each bit chosen is one bit of
    // the victim index, most significant first.
    always_comb begin
        logic [IDX_W-1:0] node;
        logic             dir;
        node   = IDX_W'(1);
        victim = '0;
        for (int l = 0; l < IDX_W; l++) begin
            dir                = bits[node];
            victim[IDX_W-1-l]  = dir;
            node               = (node << 1) | IDX_W'(dir);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits <= '0;
        end else if (flush) begin
            bits <= '0;
        end else begin
            bits <= bits_next;
        end
    end

endmodule

// File: rtl/btb_plru.sv
// Fully-associative branch target buffer with tree pLRU replacement.
//
// Lookup is purely combinational; updates from execute land on the next
// rising edge, so a lookup in the same cycle as an update sees old state.
//
// Parameters:
//   ENTRIES   number of entries (power of two, 2..64)
//   CTR_W     width of the per-entry saturating confidence counter
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   lookup_valid    fetch lookup is live (allows the pLRU touch)
//   lookup_pc       fetch PC
//   pred_hit        taken prediction available for lookup_pc
//   pred_target     predicted target (meaningless when pred_hit = 0)
//   upd_valid       resolved control transfer from execute
//   upd_pc          PC of the resolved branch
//   upd_target      resolved target
//   upd_taken       branch resolved taken
//   flush           synchronous invalidate-all

module btb_plru
    import btb_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int CTR_W   = CTR_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    output logic        pred_hit,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        flush
);

    localparam int               IDX_W      = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_INIT   = CTR_W'(ctr_init_val(CTR_W));
    localparam logic [CTR_W-1:0] CTR_THRESH = CTR_W'(ctr_thresh_val(CTR_W));
    localparam logic [CTR_W-1:0] CTR_MAX    = CTR_W'(ctr_max_val(CTR_W));

    btb_entry_t       ent [ENTRIES];
    logic [CTR_W-1:0] ctr [ENTRIES];

    logic             lk_hit;
    logic [IDX_W-1:0] lk_idx;
    logic             up_hit;
    logic [IDX_W-1:0] up_hit_idx;
    logic             have_free;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] victim;

    logic             upd_write;
    logic [IDX_W-1:0] upd_idx;
    logic [CTR_W-1:0] new_ctr;
    logic             new_valid;
    logic             touch_a_valid;
    logic             touch_b_valid;

    // Word-offset bits never take part in tag comparison.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Tags are unique among valid entries, so at most one match exists and
    // a simple OR-style scan yields its index.
    always_comb begin
        lk_hit     = 1'b0;
        lk_idx     = '0;
        up_hit     = 1'b0;
        up_hit_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ent[i].valid && ent[i].tag == lookup_pc[31:2]) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
            if (ent[i].valid && ent[i].tag == upd_pc[31:2]) begin
                up_hit     = 1'b1;
                up_hit_idx = IDX_W'(i);
            end
        end
    end

    // Scan downwards so the lowest-index invalid entry is the one kept.
    always_comb begin
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!ent[i].valid) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
        end
    end

    assign pred_hit    = !rst && lk_hit && (ctr[lk_idx] >= CTR_THRESH);
    assign pred_target = ent[lk_idx].target;

    assign touch_a_valid = lookup_valid && lk_hit;

    // Update decode: hit-taken strengthens, hit-not-taken weakens and may
    // retire the entry, miss-taken allocates, miss-not-taken is ignored.
    always_comb begin
        upd_write     = 1'b0;
        upd_idx       = up_hit_idx;
        new_ctr       = ctr[up_hit_idx];
        new_valid     = 1'b1;
        touch_b_valid = 1'b0;
        if (upd_valid && !flush) begin
            if (up_hit) begin
                upd_write = 1'b1;
                if (upd_taken) begin
                    new_ctr       = (ctr[up_hit_idx] == CTR_MAX) ? CTR_MAX
                                                                 : ctr[up_hit_idx] + 1'b1;
                    touch_b_valid = 1'b1;
                end else begin
                    new_ctr       = (ctr[up_hit_idx] == '0) ? '0
                                                           : ctr[up_hit_idx] - 1'b1;
                    new_valid     = (new_ctr != '0);
                    touch_b_valid = new_valid;
                end
            end else if (upd_taken) begin
                upd_write     = 1'b1;
                upd_idx       = have_free ? free_idx : victim;
                new_ctr       = CTR_INIT;
                touch_b_valid = 1'b1;
            end
        end
    end

    // Only valid bits are reset; tag/target/counter are qualified by valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent[i].valid <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent[i].valid <= 1'b0;
            end
        end else if (upd_write) begin
            ent[upd_idx].valid <= new_valid;
            ctr[upd_idx]       <= new_ctr;
            if (upd_taken) begin
                ent[upd_idx].tag    <= upd_pc[31:2];
                ent[upd_idx].target <= upd_target;
            end
        end
    end

    plru_tree #(
        .ENTRIES(ENTRIES)
    ) u_plru (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .touch_a_valid(touch_a_valid),
        .touch_a_idx  (lk_idx),
        .touch_b_valid(touch_b_valid),
        .touch_b_idx  (upd_idx),
        .victim       (victim)
    );

endmodule
